// File: rtl/prog_loader_pkg.sv
// Shared types and default sizes for the program loader.
package prog_loader_pkg;

  localparam int ADDR_W_DEF    = 12;
  localparam int MAX_WORDS_DEF = 4096;
  localparam int WORD_W        = 9;

  typedef logic [WORD_W-1:0] mc_word_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

endpackage

// File: rtl/prog_loader_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a machine-code image into instruction memory, then releases the core
// from reset and times its run until core_done.
//
// state   | meaning
// IDLE    | core held in reset, waiting for start
// LOAD    | accepting words, one write per accepted word
// RELEASE | one cycle for the final write to land, core still in reset
// RUN     | core running, run_cycles counting
// ERROR   | image exceeded capacity, waiting for start
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CYC_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  mc_word_t          in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              core_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output mc_word_t          wr_data,
  output logic              core_reset,
  output logic              busy,
  output logic              run_done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count,
  output logic [CYC_W-1:0]  run_cycles
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              at_last_addr;
  logic              restart;
  logic              overflow;

  assign accept       = in_valid && in_ready;
  assign at_last_addr = (ptr == LAST_ADDR);
  assign restart      = start && ((state == ST_IDLE) || (state == ST_ERROR));
  assign overflow     = accept && !in_last && at_last_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (accept && in_last) begin
          state_nxt = ST_RELEASE;
        end else if (overflow) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_RELEASE: state_nxt = ST_RUN;
      ST_RUN:     if (core_done) state_nxt = ST_IDLE;
      ST_ERROR:   if (start) state_nxt = ST_LOAD;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == ST_LOAD);
    core_reset = (state != ST_RUN);
    busy       = (state == ST_LOAD) || (state == ST_RELEASE) || (state == ST_RUN);
  end

  // The pointer parks on the last address instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      word_count   <= '0;
      run_done     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr    <= ptr;
        wr_data    <= in_data;
        word_count <= word_count + (ADDR_W+1)'(1);
        if (!at_last_addr) begin
          ptr <= ptr + ADDR_W'(1);
        end
      end
      if (overflow) begin
        overflow_err <= 1'b1;
      end
      if ((state == ST_RUN) && core_done) begin
        run_done <= 1'b1;
      end
      if (restart) begin
        ptr          <= '0;
        word_count   <= '0;
        run_done     <= 1'b0;
        overflow_err <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (CYC_W)
  ) u_run_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (state == ST_RUN),
    .clr   (restart),
    .cnt   (run_cycles)
  );

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory address width; matches the 12-bit PC.
REQ-002 Parameter MAX_WORDS, default 4096, instruction-memory capacity in words.
REQ-003 Parameter CYC_W, default 16, width of the run-cycle counter.
REQ-004 The module SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be (name, direction, width, meaning):
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin a load session
in_valid  in  1  machine-code word offered
in_data  in  9  machine-code word
in_last  in  1  offered word is the final word of the program
in_ready  out  1  loader accepts the word this cycle
core_done  in  1  processor done flag
wr_en  out  1  instruction-memory write strobe
wr_addr  out  ADDR_W  instruction-memory write address
wr_data  out  9  instruction-memory write data
core_reset  out  1  active-high hold-in-reset to the program counter and core
busy  out  1  session in progress: LOAD, RELEASE or RUN
run_done  out  1  program finished; sticky until next start
overflow_err  out  1  image exceeded MAX_WORDS; sticky until next start
word_count  out  ADDR_W+1  number of words accepted this session
run_cycles  out  CYC_W  cycles spent in RUN, saturating

Function
REQ-006 The FSM SHALL have five states: IDLE, LOAD, RELEASE, RUN, ERROR.
REQ-007 IDLE: start moves to LOAD, clears word_count, run_cycles, run_done and overflow_err, and zeroes the address pointer.
REQ-008 A start pulse in any state other than IDLE or ERROR SHALL be ignored.
REQ-009 in_ready SHALL be 1 exactly when the state is LOAD.
REQ-010 A word is accepted when in_valid and in_ready are both high on a rising edge.
REQ-011 An accepted word on edge N SHALL produce, in the cycle following N, wr_en=1 for one cycle, wr_addr equal to the pointer, and wr_data equal to in_data. The write latency is 1 cycle.
REQ-012 Each accepted word SHALL increment the pointer and word_count.
REQ-013 Back-to-back words SHALL be accepted at one word per cycle with no bubbles.
REQ-014 An accepted word with in_last=1 SHALL move LOAD to RELEASE.
REQ-015 RELEASE SHALL last exactly 1 cycle, keeping core_reset=1 so the final write lands before the core starts; it then moves to RUN.
REQ-016 core_reset SHALL be 1 in IDLE, LOAD, RELEASE and ERROR, and 0 only in RUN.
REQ-017 RUN: run_cycles SHALL increment each cycle and saturate at all-ones.
REQ-018 RUN: core_done=1 SHALL set run_done and return the FSM to IDLE, which re-asserts core_reset.
REQ-019 core_done SHALL be ignored in every state except RUN.
REQ-020 Overflow: an accepted word with in_last=0 while the pointer equals MAX_WORDS-1 SHALL still be written. The FSM then moves to ERROR and sets overflow_err.
REQ-021 ERROR SHALL hold in_ready=0 and core_reset=1. Only start leaves ERROR, behaving as in REQ-007.
REQ-022 A one-word program (in_last on the first word) is legal: word_count=1, then RELEASE.
REQ-023 in_valid while not in LOAD SHALL have no effect.
REQ-024 The pointer SHALL never wrap. The address MAX_WORDS-1 is the last address written.

Reset
REQ-025 Asserting reset (low) SHALL, asynchronously and in any state including mid-load or mid-run, force the following: state IDLE, core_reset=1, wr_en=0, in_ready=0, busy=0, run_done=0, overflow_err=0, word_count=0, run_cycles=0, wr_addr=0, wr_data=0.
REQ-026 Memory contents written before reset SHALL be left as-is; the loader issues no writes during or after reset.

Structure
REQ-027 A shared package SHALL hold the state enum, the 9-bit machine-code word typedef, and the ADDR_W and MAX_WORDS defaults.
REQ-028 One sub-module, sat_counter, SHALL implement run_cycles as a parameterised-width counter with enable, clear and saturation.
REQ-029 All outputs SHALL be registered except in_ready, core_reset and busy, which decode the state.

Verification
REQ-030 Reset the block, then pulse start and stream 3 words (0x1A3, 0x005, 0x1FF; last on the third). Required response: wr_en at addresses 0,1,2 with that data on consecutive cycles, word_count=3, RELEASE for 1 cycle, then core_reset=0.
REQ-031 In RUN, assert core_done 10 cycles after core_reset falls. Required response: run_cycles=10, run_done=1, state IDLE, core_reset=1.
REQ-032 Drive in_valid with gaps (pattern 1,0,0,1,1; last on the third accepted word). Required response: exactly 3 writes, addresses 0-2, no write in any gap cycle.
REQ-033 With MAX_WORDS=4, stream 5 words with no in_last. Required response: 4 writes at addresses 0-3, overflow_err=1, in_ready=0 from the fifth word onward, core_reset stays 1, and a new start clears overflow_err.
REQ-034 Pull reset low during LOAD after 2 words and during RUN. Required response: all outputs immediately take their REQ-025 values, and no further wr_en pulses.
REQ-035 Pulse start during LOAD and during RUN. Required response: no effect.
REQ-036 Assert core_done in IDLE and LOAD. Required response: run_done stays 0.
